// File: rtl/i2c_mem_slave_pkg.sv
// i2c_mem_slave_pkg
//   Shared types and constants for the I2C memory target.
//   state_t        : protocol FSM states
//   BIT_CNT_W      : width of the per-byte bit counter (counts 0..8)
//   BITS_PER_BYTE  : bit count at which a byte is complete
//   ACK / NACK     : SDA level of the acknowledge slot
package i2c_mem_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        RD_DONE,
        IGNORE
    } state_t;

    localparam int                   BIT_CNT_W     = 4;
    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;
    localparam logic                 ACK           = 1'b0;
    localparam logic                 NACK          = 1'b1;

endpackage

// File: rtl/i2c_mem_slave_if.sv
// i2c_mem_slave_if
//   Pad triplets and write-strobe bus of the I2C memory target.
//   scl_i/sda_i       : pad levels seen by the target
//   scl_o/scl_t       : SCL drive value / tristate (1 = released)
//   sda_o/sda_t       : SDA drive value / tristate (1 = released)
//   busy              : addressed and not yet stopped
//   wr_stb/addr/data  : one pulse per byte stored into the memory
//   Modports: slave (the target), master (bus side / bench).
interface i2c_mem_slave_if #(
    parameter int AW = 4
);
    logic          scl_i;
    logic          scl_o;
    logic          scl_t;
    logic          sda_i;
    logic          sda_o;
    logic          sda_t;
    logic          busy;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport slave (
        input  scl_i, sda_i,
        output scl_o, scl_t, sda_o, sda_t, busy, wr_stb, wr_addr, wr_data
    );

    modport master (
        output scl_i, sda_i,
        input  scl_o, scl_t, sda_o, sda_t, busy, wr_stb, wr_addr, wr_data
    );

endinterface

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
//   Two-flop synchronizer followed by a stability filter for one I2C pad.
//   The filtered level only follows the synchronized pad after FILT_LEN
//   consecutive samples that disagree with it; shorter glitches vanish.
//   clk, rst : clock, async active-high reset (level resets high = idle bus)
//   pad_i    : raw pad level
//   level    : filtered level
//   rise     : 1-cycle pulse, coincident with level going 0->1
//   fall     : 1-cycle pulse, coincident with level going 1->0
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pad_i};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] != level) begin
                // cnt holds how many disagreeing samples preceded this one
                if (cnt == CW'(FILT_LEN - 1)) begin
                    level <= sync[1];
                    rise  <= sync[1];
                    fall  <= ~sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/i2c_mem_slave.sv
// i2c_mem_slave
//   I2C target with a small byte-addressed memory. A write sets the byte
//   pointer and stores following bytes; a read returns bytes from the
//   pointer. The pointer auto-increments (wrapping) and survives STOP.
//   Optional feature macro: I2C_MEM_STRETCH_EN -- holds SCL low for STRETCH
//   clk cycles after every acknowledge slot. Without it scl_t is tied high.
//   Ports:
//     clk  : system clock, at least 16x the SCL rate
//     rst  : asynchronous active-high reset
//     bus  : i2c_mem_slave_if.slave (pads, busy, write strobe)
module i2c_mem_slave #(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         MEM_DEPTH = 16,
    parameter int         FILT_LEN  = 3
`ifdef I2C_MEM_STRETCH_EN
   ,parameter int         STRETCH   = 8
`endif
) (
    input  logic           clk,
    input  logic           rst,
    i2c_mem_slave_if.slave bus
);
    import i2c_mem_slave_pkg::*;

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .rst   (rst),
        .pad_i (bus.scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .rst   (rst),
        .pad_i (bus.sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // SDA moving while filtered SCL is high can only be a bus condition
    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shreg;
    logic                 rw;
    logic [AW-1:0]        ptr;
    logic [7:0]           mem [MEM_DEPTH];
    logic                 sda_t_r;
    logic                 busy_r;
    logic                 wr_stb_r;
    logic [AW-1:0]        wr_addr_r;
    logic [7:0]           wr_data_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_t_r   <= 1'b1;
            busy_r    <= 1'b0;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_stb_r <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_t_r <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                busy_r  <= 1'b0;
                sda_t_r <= 1'b1;
            end else if (scl_rise) begin
                case (state)
                    ADDR, PTR, WR: begin
                        if (bit_cnt < BITS_PER_BYTE) begin
                            shreg   <= {shreg[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RD: begin
                        if (bit_cnt < BITS_PER_BYTE) bit_cnt <= bit_cnt + 1'b1;
                    end
                    RD_ACK: begin
                        // NACK ends the read; ACK is acted on at the next fall
                        if (sda_lvl == NACK) state <= RD_DONE;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                // The first fall after START arrives with bit_cnt==0 and is ignored
                case (state)
                    ADDR: begin
                        if (bit_cnt == BITS_PER_BYTE) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                rw      <= shreg[0];
                                busy_r  <= 1'b1;
                                sda_t_r <= ACK;
                                state   <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt <= '0;
                        if (rw) begin
                            // first read bit goes out on the ACK-clock fall
                            shreg   <= mem[ptr];
                            sda_t_r <= mem[ptr][7];
                            ptr     <= ptr + 1'b1;
                            state   <= RD;
                        end else begin
                            sda_t_r <= 1'b1;
                            state   <= PTR;
                        end
                    end
                    PTR: begin
                        if (bit_cnt == BITS_PER_BYTE) begin
                            ptr     <= shreg[AW-1:0];
                            sda_t_r <= ACK;
                            state   <= PTR_ACK;
                        end
                    end
                    WR: begin
                        if (bit_cnt == BITS_PER_BYTE) begin
                            mem[ptr]  <= shreg;
                            wr_stb_r  <= 1'b1;
                            wr_addr_r <= ptr;
                            wr_data_r <= shreg;
                            ptr       <= ptr + 1'b1;
                            sda_t_r   <= ACK;
                            state     <= WR_ACK;
                        end
                    end
                    PTR_ACK, WR_ACK: begin
                        sda_t_r <= 1'b1;
                        bit_cnt <= '0;
                        state   <= WR;
                    end
                    RD: begin
                        if (bit_cnt == BITS_PER_BYTE) begin
                            sda_t_r <= 1'b1;
                            state   <= RD_ACK;
                        end else begin
                            sda_t_r <= shreg[6];
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                    RD_ACK: begin
                        // only reached after the master ACKed on the rise
                        shreg   <= mem[ptr];
                        sda_t_r <= mem[ptr][7];
                        ptr     <= ptr + 1'b1;
                        bit_cnt <= '0;
                        state   <= RD;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef I2C_MEM_STRETCH_EN
    localparam int SW = $clog2(STRETCH + 2);

    // Fall that closes an acknowledge slot; an RD_ACK fall implies ACK
    logic ack_slot_fall;
    assign ack_slot_fall = scl_fall & ~start_det & ~stop_det &
                           ((state == ADDR_ACK) || (state == PTR_ACK) ||
                            (state == WR_ACK)   || (state == RD_ACK));

    logic [SW-1:0] stretch_cnt;
    logic          scl_t_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch_cnt <= '0;
            scl_t_r     <= 1'b1;
        end else if (start_det || stop_det) begin
            stretch_cnt <= '0;
            scl_t_r     <= 1'b1;
        end else if (ack_slot_fall && (STRETCH > 0)) begin
            stretch_cnt <= SW'(STRETCH);
            scl_t_r     <= 1'b0;
        end else if (stretch_cnt > SW'(1)) begin
            stretch_cnt <= stretch_cnt - 1'b1;
        end else begin
            stretch_cnt <= '0;
            scl_t_r     <= 1'b1;
        end
    end

    assign bus.scl_t = scl_t_r;
`else
    assign bus.scl_t = 1'b1;
`endif

    assign bus.scl_o   = 1'b0;
    assign bus.sda_o   = 1'b0;
    assign bus.sda_t   = sda_t_r;
    assign bus.busy    = busy_r;
    assign bus.wr_stb  = wr_stb_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// tb_i2c_mem_slave
//   Bit-banged I2C master against i2c_mem_slave (DEV_ADDR 0x50, 16 bytes).
//   Stimulus pushes expected write strobes / read bytes into queues; a
//   monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_i2c_mem_slave;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_mem_slave_if #(.AW(4)) bus ();

    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_line, sda_line;
    assign scl_line  = scl_m & (bus.scl_t | bus.scl_o);
    assign sda_line  = sda_m & (bus.sda_t | bus.sda_o);
    assign bus.scl_i = scl_line;
    assign bus.sda_i = sda_line;

    i2c_mem_slave #(.DEV_ADDR(7'h50), .MEM_DEPTH(16), .FILT_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  obs_rd_q[$];
    logic [7:0]  mon_obs;
    int          wr_cnt       = 0;
    int          scl_low_cnt  = 0;
    logic        sda_low_seen = 1'b0;
    logic        busy_seen    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!bus.sda_t) sda_low_seen = 1'b1;
        if (bus.busy) busy_seen = 1'b1;
        if (!bus.scl_t) scl_low_cnt++;
        if (bus.wr_stb === 1'b1) begin
            wr_cnt++;
            if (exp_wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected: got addr %0h data %0h with nothing queued",
                         bus.wr_addr, bus.wr_data);
            end else begin
                check("wr_stb", {bus.wr_addr, bus.wr_data}, exp_wr_q.pop_front());
            end
        end
        while (obs_rd_q.size() > 0) begin
            mon_obs = obs_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %0h with nothing queued", mon_obs);
            end else begin
                check("rd_byte", mon_obs, exp_rd_q.pop_front());
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // release SCL and wait (bounded) for the line to go high
    task automatic scl_up();
        int t = 0;
        scl_m = 1'b1;
        while (scl_line !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (scl_line !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL scl_release: got %0b want 1 after 200 cycles", scl_line);
        end
    endtask

    task automatic i2c_start();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_up();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_up();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q);
    endtask

    // glitch 1: SCL high pulse during low phase; 2: SDA flip while SCL high
    task automatic send_bit(input logic b, input int glitch);
        wait_clk(Q); sda_m = b;
        if (glitch == 1) begin
            wait_clk(Q/2); scl_m = 1'b1; wait_clk(2); scl_m = 1'b0; wait_clk(Q - Q/2 - 2);
        end else begin
            wait_clk(Q);
        end
        scl_up();
        if (glitch == 2) begin
            wait_clk(Q/2); sda_m = ~b; wait_clk(2); sda_m = b; wait_clk(2*Q - Q/2 - 2);
        end else begin
            wait_clk(2*Q);
        end
        scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_up();
        wait_clk(Q); b = sda_line;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string name,
                             input int gbit = -1, input int gkind = 0);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i], (i == gbit) ? gkind : 0);
        recv_bit(a);
        check(name, a, exp_ack);
    endtask

    task automatic recv_byte(input logic ack_out, input logic [7:0] exp);
        logic [7:0] d;
        logic       b;
        exp_rd_q.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        obs_rd_q.push_back(d);
        send_bit(ack_out, 0);
    endtask

    initial begin
        int wr_before;

        // reset state
        wait_clk(4);
        check("rst_sda_t",   bus.sda_t,   1);
        check("rst_scl_t",   bus.scl_t,   1);
        check("rst_busy",    bus.busy,    0);
        check("rst_wr_stb",  bus.wr_stb,  0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        rst = 1'b0;
        wait_clk(4);

        // 1: write pointer 3, two data bytes
        exp_wr_q.push_back({4'd3, 8'hA5});
        exp_wr_q.push_back({4'd4, 8'h5A});
        i2c_start();
        send_byte(8'hA0, 1'b0, "t1_addr_ack");
        check("t1_busy", bus.busy, 1);
        send_byte(8'h03, 1'b0, "t1_ptr_ack");
        send_byte(8'hA5, 1'b0, "t1_d0_ack");
        send_byte(8'h5A, 1'b0, "t1_d1_ack");
        i2c_stop();
        check("t1_busy_after_stop", bus.busy, 0);

        // 2: set pointer, repeated START, read two bytes
        i2c_start();
        send_byte(8'hA0, 1'b0, "t2_addr_ack");
        send_byte(8'h03, 1'b0, "t2_ptr_ack");
        i2c_start();
        send_byte(8'hA1, 1'b0, "t2_raddr_ack");
        recv_byte(1'b0, 8'hA5);
        recv_byte(1'b1, 8'h5A);
        wait_clk(Q);
        check("t2_sda_released", bus.sda_t, 1);
        i2c_stop();

        // 3: wrong address
        wait_clk(2);
        sda_low_seen = 1'b0;
        busy_seen    = 1'b0;
        wr_before    = wr_cnt;
        i2c_start();
        send_byte(8'hA2, 1'b1, "t3_addr_nack");
        send_byte(8'h77, 1'b1, "t3_data_nack");
        i2c_stop();
        check("t3_sda_never_low", sda_low_seen, 0);
        check("t3_busy_never", busy_seen, 0);
        check("t3_no_wr_stb", wr_cnt, wr_before);

        // 4: pointer wrap on write and read
        exp_wr_q.push_back({4'd15, 8'h11});
        exp_wr_q.push_back({4'd0,  8'h22});
        i2c_start();
        send_byte(8'hA0, 1'b0, "t4_addr_ack");
        send_byte(8'h0F, 1'b0, "t4_ptr_ack");
        send_byte(8'h11, 1'b0, "t4_d0_ack");
        send_byte(8'h22, 1'b0, "t4_d1_ack");
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, 1'b0, "t4_addr2_ack");
        send_byte(8'h0F, 1'b0, "t4_ptr2_ack");
        i2c_start();
        send_byte(8'hA1, 1'b0, "t4_raddr_ack");
        recv_byte(1'b0, 8'h11);
        recv_byte(1'b1, 8'h22);
        i2c_stop();

        // 5: reset while the target drives bit 7 (=0) of mem[0]=0x22
        i2c_start();
        send_byte(8'hA0, 1'b0, "t5_addr_ack");
        send_byte(8'h00, 1'b0, "t5_ptr_ack");
        i2c_start();
        send_byte(8'hA1, 1'b0, "t5_raddr_ack");
        wait_clk(Q);
        check("t5_driving_low", bus.sda_t, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_release", bus.sda_t, 1);
        check("t5_rst_busy", bus.busy, 0);
        wait_clk(3);
        rst = 1'b0;
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, 1'b0, "t5_raddr2_ack");
        recv_byte(1'b1, 8'h00);
        i2c_stop();

        // 6: short glitches on both lines are filtered out
        exp_wr_q.push_back({4'd5, 8'h3C});
        i2c_start();
        send_byte(8'hA0, 1'b0, "t6_addr_ack", 3, 1);
        send_byte(8'h05, 1'b0, "t6_ptr_ack", 2, 2);
        send_byte(8'h3C, 1'b0, "t6_data_ack", 0, 2);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, 1'b0, "t6_addr2_ack");
        send_byte(8'h05, 1'b0, "t6_ptr2_ack", 5, 1);
        i2c_start();
        send_byte(8'hA1, 1'b0, "t6_raddr_ack");
        recv_byte(1'b1, 8'h3C);
        i2c_stop();

        wait_clk(5);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
`ifdef I2C_MEM_STRETCH_EN
        check("scl_stretch_seen", (scl_low_cnt != 0), 1);
`else
        check("scl_never_driven", scl_low_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
